// File: rtl/giris_cikis_yanitlayici.sv
// I/O responder: UART TX FIFO, FIFO status and optional timer/compare/interrupt registers.
// Define ZAMANLAYICI_EN to build the timer block; otherwise offsets 2-4 decode as unmapped.
module giris_cikis_yanitlayici #(
  parameter int unsigned FIFO_DERINLIK = 8,
  parameter int unsigned ADRES_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               giris_cikis_aktif_i,
  input  logic               bellege_yaz_i,
  input  logic               bellekten_oku_i,
  input  logic [ADRES_W-1:0] adres_i,
  input  logic [31:0]        veri_i,
  output logic [31:0]        veri_o,
  output logic               veri_gecerli_o,
  output logic               durdur_o,
  output logic               hata_o,
  output logic [7:0]         uart_tx_veri_o,
  output logic               uart_tx_gecerli_o,
  input  logic               uart_tx_hazir_i,
  output logic               kesme_o
);

  localparam int unsigned PW = $clog2(FIFO_DERINLIK);
  localparam logic [PW:0] LDolu = FIFO_DERINLIK[PW:0];

  typedef enum logic [1:0] {Bosta, BekleFifo, Yanit} durum_t;

  durum_t        r_durum;
  logic [7:0]    r_fifo [FIFO_DERINLIK];
  logic [PW-1:0] r_yaz_ptr;
  logic [PW-1:0] r_oku_ptr;
  logic [PW:0]   r_sayi;
  logic [31:0]   r_veri;
  logic          r_gecerli;
  logic          r_hata;

  logic [2:0]  w_ofs;
  logic        w_oku;
  logic        w_tx_yaz;
  logic        w_dolu;
  logic        w_bos;
  logic        w_pop;
  logic        w_push;
  logic        w_kabul;
  logic        w_yazma;
  logic        w_esleme;
  logic [31:0] w_oku_veri;
  logic        w_unused;

  assign w_ofs    = adres_i[4:2];
  // A simultaneous write and read is treated as a write only.
  assign w_oku    = bellekten_oku_i && !bellege_yaz_i;
  assign w_tx_yaz = bellege_yaz_i && (w_ofs == 3'd0);
  assign w_dolu   = (r_sayi == LDolu);
  assign w_bos    = (r_sayi == '0);
  assign w_pop    = uart_tx_hazir_i && !w_bos;
  assign w_kabul  = ((r_durum == Bosta) && giris_cikis_aktif_i && !(w_tx_yaz && w_dolu)) ||
                    ((r_durum == BekleFifo) && !w_dolu);
  assign w_push   = w_kabul && w_tx_yaz;
  assign w_yazma  = w_kabul && bellege_yaz_i;
  assign w_unused = ^{adres_i, veri_i};

  assign durdur_o          = giris_cikis_aktif_i && (r_durum != Yanit);
  assign veri_o            = r_veri;
  assign veri_gecerli_o    = r_gecerli;
  assign hata_o            = r_hata;
  assign uart_tx_veri_o    = r_fifo[r_oku_ptr];
  assign uart_tx_gecerli_o = !w_bos;

`ifdef ZAMANLAYICI_EN
  logic [31:0] r_sayac;
  logic [31:0] r_karsi;
  logic        r_bekleyen;
  logic [31:0] w_sayac_d;
  logic [31:0] w_karsi_d;
  logic        w_sil;

  always_comb begin
    w_sayac_d = r_sayac + 32'd1;
    w_karsi_d = r_karsi;
    if (w_yazma && (w_ofs == 3'd2)) w_sayac_d = veri_i;
    if (w_yazma && (w_ofs == 3'd3)) w_karsi_d = veri_i;
  end

  assign w_sil    = w_yazma && (w_ofs == 3'd4) && veri_i[0];
  assign w_esleme = (w_ofs <= 3'd4);
  assign kesme_o  = r_bekleyen;

  // Match is taken on the next-state values so the flag rises with the counter reaching compare.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_sayac    <= '0;
      r_karsi    <= '1;
      r_bekleyen <= 1'b0;
    end else begin
      r_sayac    <= w_sayac_d;
      r_karsi    <= w_karsi_d;
      r_bekleyen <= (w_sayac_d == w_karsi_d) || (r_bekleyen && !w_sil);
    end
  end
`else
  assign w_esleme = (w_ofs <= 3'd1);
  assign kesme_o  = 1'b0;
`endif

  always_comb begin
    w_oku_veri = '0;
    case (w_ofs)
      3'd1:    w_oku_veri = {30'b0, w_dolu, w_bos};
`ifdef ZAMANLAYICI_EN
      3'd2:    w_oku_veri = r_sayac;
      3'd3:    w_oku_veri = r_karsi;
      3'd4:    w_oku_veri = {31'b0, r_bekleyen};
`endif
      default: w_oku_veri = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_durum   <= Bosta;
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      r_sayi    <= '0;
      r_veri    <= '0;
      r_gecerli <= 1'b0;
      r_hata    <= 1'b0;
    end else begin
      case (r_durum)
        Bosta: begin
          if (giris_cikis_aktif_i) r_durum <= (w_tx_yaz && w_dolu) ? BekleFifo : Yanit;
        end
        BekleFifo: begin
          if (!w_dolu) r_durum <= Yanit;
        end
        default: r_durum <= Bosta;
      endcase

      r_gecerli <= w_kabul && w_oku;
      r_veri    <= (w_kabul && w_oku) ? w_oku_veri : '0;
      r_hata    <= w_kabul && (bellege_yaz_i || bellekten_oku_i) && !w_esleme;

      if (w_push) begin
        r_fifo[r_yaz_ptr] <= veri_i[7:0];
        r_yaz_ptr         <= r_yaz_ptr + 1'b1;
      end
      if (w_pop) r_oku_ptr <= r_oku_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_sayi <= r_sayi + 1'b1;
        2'b01:   r_sayi <= r_sayi - 1'b1;
        default: r_sayi <= r_sayi;
      endcase
    end
  end

endmodule
